// File: rtl/fp_pkg.sv
// Shared single-precision field widths, FSM state and float layout
// for the sequential subtractor.
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int SIG_W    = 25;
  localparam int EXP_BIAS = 127;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ARITH,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  function automatic logic [31:0] pack_fp(
    input logic              s,
    input logic [EXP_W-1:0]  e,
    input logic [FRAC_W-1:0] f
  );
    return {s, e, f};
  endfunction

  // Hidden one at bit 24, guard at bit 0; exp==0 flushes to zero.
  function automatic logic [SIG_W-1:0] unpack_sig(
    input fp32_t v
  );
    return (v.exp == '0) ? '0 : {1'b1, v.frac, 1'b0};
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// 25-bit leading-zero counter; all-zero input yields 25.
// Used by the single-cycle normaliser.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] v,
  output logic [4:0]       cnt
);

  always_comb begin
    cnt = 5'd25;
    for (int i = 0; i < SIG_W; i++) begin
      if (v[i]) cnt = 5'(SIG_W - 1 - i);
    end
  end

endmodule

// File: rtl/fsub_seq.sv
// Multi-cycle IEEE-754 single subtractor X = A - B, truncating.
// FSUB_FAST_NORM_EN selects a one-cycle LZC/barrel normaliser.
module fsub_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] X
);

  state_t state;

  fp32_t a_r;
  fp32_t b_r;
  fp32_t fb;
  fp32_t lead;
  fp32_t sml;

  logic             a_big;
  logic [EXP_W-1:0] d;
  logic [SIG_W-1:0] sig_l;
  logic [SIG_W-1:0] sig_s;
  logic [SIG_W-1:0] sh_s;

  logic             sign_r;
  logic             sub_r;
  logic [EXP_W-1:0] exp_r;
  logic [SIG_W-1:0] sl_r;
  logic [SIG_W-1:0] ss_r;
  logic [SIG_W:0]   sig_r;
  logic [EXP_W:0]   exp_inc;

  assign fb    = {~b_r.sign, b_r.exp, b_r.frac};
  assign a_big = a_r[30:0] >= b_r[30:0];
  assign lead  = a_big ? a_r : fb;
  assign sml   = a_big ? fb : a_r;
  assign d     = lead.exp - sml.exp;
  assign sig_l = unpack_sig(lead);
  assign sig_s = unpack_sig(sml);
  assign sh_s  = (d >= 8'd25) ? '0 : (sig_s >> d);

  assign exp_inc = {1'b0, exp_r} + 9'd1;

`ifdef FSUB_FAST_NORM_EN
  logic [4:0]        lz;
  logic [EXP_W-1:0]  exp_n;
  logic [FRAC_W-1:0] frac_n;

  fp_lzc u_lzc (
    .v   (sig_r[SIG_W-1:0]),
    .cnt (lz)
  );

  assign exp_n  = exp_r - {3'b0, lz};
  assign frac_n = FRAC_W'((sig_r[SIG_W-1:0] << lz) >> 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      X         <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      sub_r     <= 1'b0;
      exp_r     <= '0;
      sl_r      <= '0;
      ss_r      <= '0;
      sig_r     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= A;
            b_r      <= B;
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          sign_r <= lead.sign;
          sub_r  <= lead.sign ^ sml.sign;
          exp_r  <= lead.exp;
          sl_r   <= sig_l;
          ss_r   <= sh_s;
          state  <= ARITH;
        end
        ARITH: begin
          if (sub_r) sig_r <= {1'b0, sl_r - ss_r};
          else       sig_r <= {1'b0, sl_r} + {1'b0, ss_r};
          state <= NORM;
        end
        NORM: begin
          if (sig_r[SIG_W]) begin
            if (exp_inc >= 9'd255)
              X <= pack_fp(sign_r, '1, '0);
            else
              X <= pack_fp(sign_r, exp_inc[EXP_W-1:0],
                           sig_r[SIG_W-1:2]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (sig_r[SIG_W-1:0] == '0) begin
            X         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef FSUB_FAST_NORM_EN
          end else if ({3'b0, lz} >= exp_r) begin
            X         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            X         <= pack_fp(sign_r, exp_n, frac_n);
            out_valid <= 1'b1;
            state     <= DONE;
          end
`else
          end else if (sig_r[SIG_W-1]) begin
            X         <= pack_fp(sign_r, exp_r, sig_r[23:1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp_r <= 8'd1) begin
            X         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            // finish in the same cycle as the shift that normalises
            sig_r <= {1'b0, sig_r[SIG_W-2:0], 1'b0};
            exp_r <= exp_r - 8'd1;
            if (sig_r[SIG_W-2]) begin
              X <= pack_fp(sign_r, exp_r - 8'd1,
                           sig_r[FRAC_W-1:0]);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
